// File: rtl/palin_pkg.sv
// Shared definitions for the palindrome-detector feed path: FSM encoding,
// frame counter width and the default idle line level.
package palin_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_e;

  localparam int unsigned CNT_W        = 16;
  localparam logic        IDLE_BIT_DEF = 1'b0;

endpackage

// File: rtl/palin_hold_buf.sv
// One-word holding register with a full flag. A load wins over a drain in the
// same cycle so a word can be swapped in while the old one leaves.
module palin_hold_buf #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic              drain_i,
  output logic [WORD_W-1:0] data_o,
  output logic              full_o
);

  logic [WORD_W-1:0] data_d, data_q;
  logic              full_d, full_q;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (drain_i) begin
      full_d = 1'b0;
    end
    if (load_i) begin
      data_d = load_data_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/palin_bit_serializer.sv
// Parallel-to-serial feeder for the palindrome detector: valid/ready word input,
// one bit per cycle out, with a one-word buffer so frames run back to back.
module palin_bit_serializer
  import palin_pkg::*;
#(
  parameter int unsigned WORD_W    = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = IDLE_BIT_DEF,
  parameter int unsigned CNT_W     = palin_pkg::CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              SOUT,
  output logic              SOUT_VALID,
  output logic              SOUT_LAST,
  output logic              BUSY,
  output logic [CNT_W-1:0]  WORD_CNT
);

  localparam int unsigned IdxW = $clog2(WORD_W);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_W - 1);

  state_e            state_d, state_q;
  logic [WORD_W-1:0] shift_d, shift_q;
  logic [IdxW-1:0]   idx_d, idx_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  logic              hold_full, hold_load, hold_drain;
  logic [WORD_W-1:0] hold_data;
  logic              accept, last_bit;
  logic [WORD_W-1:0] shift_adv;

  palin_hold_buf #(
    .WORD_W (WORD_W)
  ) u_hold (
    .clk_i       (CLK),
    .rst_i       (RST),
    .load_i      (hold_load),
    .load_data_i (DIN),
    .drain_i     (hold_drain),
    .data_o      (hold_data),
    .full_o      (hold_full)
  );

  assign DIN_READY = !RST && !hold_full;
  assign accept    = DIN_VALID && DIN_READY;
  assign last_bit  = (state_q == ST_SHIFT) && (idx_q == LastIdx);
  // The bit on SOUT always sits at the outgoing end of the shift register.
  assign shift_adv = MSB_FIRST ? {shift_q[WORD_W-2:0], 1'b0} : {1'b0, shift_q[WORD_W-1:1]};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d = DIN;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          cnt_d = cnt_q + CNT_W'(1);
          idx_d = '0;
          if (hold_full) begin
            shift_d    = hold_data;
            hold_drain = 1'b1;
          end else if (accept) begin
            shift_d = DIN;
          end else begin
            shift_d = '0;
            state_d = ST_IDLE;
          end
        end else begin
          shift_d   = shift_adv;
          idx_d     = idx_q + IdxW'(1);
          hold_load = accept;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign SOUT_VALID = (state_q == ST_SHIFT);
  assign SOUT       = SOUT_VALID ? (MSB_FIRST ? shift_q[WORD_W-1] : shift_q[0]) : IDLE_BIT;
  assign SOUT_LAST  = last_bit;
  assign BUSY       = (state_q == ST_SHIFT) || hold_full;
  assign WORD_CNT   = cnt_q;

endmodule

// File: tb/tb_palin_bit_serializer.sv
// Bench for palin_bit_serializer: an MSB-first 16-bit-counter instance and an
// LSB-first instance with a 4-bit counter (for wrap), checked against a bit-queue model.
module tb_palin_bit_serializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] din0 = '0, din1 = '0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic       rdy0, rdy1, so0, so1, sv0, sv1, sl0, sl1, bz0, bz1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  always #5 CLK = ~CLK;

  palin_bit_serializer #(.WORD_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .DIN(din0), .DIN_VALID(v0), .DIN_READY(rdy0), .SOUT(so0),
    .SOUT_VALID(sv0), .SOUT_LAST(sl0), .BUSY(bz0), .WORD_CNT(cnt0)
  );

  palin_bit_serializer #(.WORD_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(4)) dut_b (
    .CLK(CLK), .RST(RST), .DIN(din1), .DIN_VALID(v1), .DIN_READY(rdy1), .SOUT(so1),
    .SOUT_VALID(sv1), .SOUT_LAST(sl1), .BUSY(bz1), .WORD_CNT(cnt1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: pending output bits per channel, each entry {bit, last}.
  logic [1:0]  bq [2][$];
  logic [15:0] mcnt [2];
  logic [63:0] coll [2];
  int          lastc [2];
  int          run [2];
  int          maxrun [2];
  bit          started = 1'b0;

  task automatic chk(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s ch%0d t=%0t: got %0h want %0h", nm, ch, $time, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    for (int ch = 0; ch < 2; ch++) begin
      logic [7:0]  w;
      logic        v, acc, msb;
      logic [1:0]  e;
      logic [15:0] mask;
      w    = (ch == 0) ? din0 : din1;
      v    = (ch == 0) ? v0 : v1;
      msb  = (ch == 0);
      mask = (ch == 0) ? 16'hFFFF : 16'h000F;
      if (RST) begin
        bq[ch].delete();
        mcnt[ch] = '0;
      end else begin
        acc = v && (bq[ch].size() <= 8);
        if (bq[ch].size() > 0) begin
          e = bq[ch].pop_front();
          if (e[0]) mcnt[ch] = (mcnt[ch] + 16'd1) & mask;
        end
        if (acc) begin
          for (int i = 0; i < 8; i++) bq[ch].push_back({msb ? w[7-i] : w[i], i == 7});
        end
      end
    end
  end

  always @(negedge CLK) begin
    #2;
    if (started) begin
      for (int ch = 0; ch < 2; ch++) begin
        logic ne, a_rdy, a_so, a_sv, a_sl, a_bz;
        logic [15:0] a_cnt;
        ne    = bq[ch].size() > 0;
        a_rdy = (ch == 0) ? rdy0 : rdy1;
        a_so  = (ch == 0) ? so0 : so1;
        a_sv  = (ch == 0) ? sv0 : sv1;
        a_sl  = (ch == 0) ? sl0 : sl1;
        a_bz  = (ch == 0) ? bz0 : bz1;
        a_cnt = (ch == 0) ? cnt0 : {12'd0, cnt1};
        chk("din_ready", ch, {31'd0, a_rdy}, {31'd0, !RST && bq[ch].size() <= 8});
        chk("sout", ch, {31'd0, a_so}, {31'd0, ne ? bq[ch][0][1] : 1'b0});
        chk("sout_valid", ch, {31'd0, a_sv}, {31'd0, ne});
        chk("sout_last", ch, {31'd0, a_sl}, {31'd0, ne ? bq[ch][0][0] : 1'b0});
        chk("busy", ch, {31'd0, a_bz}, {31'd0, ne});
        chk("word_cnt", ch, {16'd0, a_cnt}, {16'd0, mcnt[ch]});
        if (a_sv) begin
          coll[ch] = {coll[ch][62:0], a_so};
          run[ch]++;
          if (run[ch] > maxrun[ch]) maxrun[ch] = run[ch];
        end else begin
          run[ch] = 0;
        end
        if (a_sl) lastc[ch]++;
      end
    end
  end

  task automatic clr_stats();
    for (int ch = 0; ch < 2; ch++) begin
      coll[ch] = '0; lastc[ch] = 0; run[ch] = 0; maxrun[ch] = 0;
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input int ch, input logic [7:0] w);
    int t;
    if (ch == 0) begin din0 = w; v0 = 1'b1; end
    else begin din1 = w; v1 = 1'b1; end
    #1;
    t = 0;
    while (!((ch == 0) ? rdy0 : rdy1) && t < 50) begin
      @(negedge CLK); #1; t++;
    end
    if (t >= 50) chk("ready_timeout", ch, 32'd0, 32'd1);
    @(negedge CLK);
  endtask

  task automatic drain(input int ch);
    int t;
    v0 = 1'b0; v1 = 1'b0;
    t = 0;
    while (bq[ch].size() > 0 && t < 100) begin @(negedge CLK); t++; end
    if (t >= 100) chk("drain_timeout", ch, 32'd0, 32'd1);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    mcnt[0] = '0; mcnt[1] = '0;
    clr_stats();
    // Reset held two cycles with a word offered: nothing may be accepted.
    v0 = 1'b1; din0 = 8'hC3; v1 = 1'b1; din1 = 8'h3C;
    @(posedge CLK); started = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready_lit", 0, {31'd0, rdy0}, 32'd0);
    chk("rst_cnt_lit", 0, {16'd0, cnt0}, 32'd0);
    RST = 1'b0; v0 = 1'b0; v1 = 1'b0;
    @(negedge CLK);

    // Single MSB-first word.
    clr_stats();
    send(0, 8'hA5);
    drain(0);
    chk("a5_bits_lit", 0, coll[0][31:0], 32'h0000_00A5);
    chk("a5_last_lit", 0, lastc[0], 32'd1);
    chk("a5_cnt_lit", 0, {16'd0, cnt0}, 32'd1);
    chk("a5_model_cnt_lit", 0, {16'd0, mcnt[0]}, 32'd1);

    // Back-to-back words with valid held high.
    clr_stats();
    send(0, 8'hFF);
    send(0, 8'h00);
    send(0, 8'h81);
    drain(0);
    chk("b2b_bits_lit", 0, coll[0][31:0], 32'h00FF_0081);
    chk("b2b_run_lit", 0, maxrun[0], 32'd24);
    chk("b2b_cnt_lit", 0, {16'd0, cnt0}, 32'd4);

    // LSB-first single word on the second instance.
    clr_stats();
    send(1, 8'h01);
    drain(1);
    chk("lsb_bits_lit", 1, coll[1][31:0], 32'h0000_0080);
    chk("lsb_cnt_lit", 1, {28'd0, cnt1}, 32'd1);

    // Reset mid-word with a word waiting in the hold buffer.
    clr_stats();
    send(0, 8'h3C);
    send(0, 8'h99);
    v0 = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_busy_lit", 0, {31'd0, bz0}, 32'd0);
    chk("abort_cnt_lit", 0, {16'd0, cnt0}, 32'd0);
    clr_stats();
    send(0, 8'h5A);
    drain(0);
    chk("after_abort_bits_lit", 0, coll[0][31:0], 32'h0000_005A);
    chk("after_abort_cnt_lit", 0, {16'd0, cnt0}, 32'd1);

    // 4-bit counter wrap: one more word (the 01 was lost to reset) plus fifteen.
    clr_stats();
    for (int i = 0; i < 16; i++) send(1, 8'(i * 37 + 5));
    drain(1);
    chk("wrap_cnt_lit", 1, {28'd0, cnt1}, 32'd0);
    chk("wrap_model_cnt_lit", 1, {16'd0, mcnt[1]}, 32'd0);
    chk("wrap_last_lit", 1, lastc[1], 32'd16);
    chk("wrap_run_lit", 1, maxrun[1], 32'd128);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
